psram_ahb_if: RTL

AHB-Lite slave front end that initiates transfers on the internal `ahb_bus_*` register bus of the PSRAM DMA register file. It decodes AHB address and data phases into single-cycle register bus strobes, generates byte selects from `HSIZE`/`HADDR`, and inserts one wait state on reads to register read data. Unaligned, oversized and out-of-window accesses receive a two-cycle ERROR response and produce no register bus activity.

---
 rtl/psram_ahb_if.sv | 118 +++++++++++
 1 files changed

// File: rtl/psram_ahb_if.sv
// AHB-Lite slave front end for the PSRAM DMA register file: turns AHB transfers into
// single-cycle register bus strobes, adds one wait state on reads, and gives a two-cycle ERROR response.
module psram_ahb_if #(
  parameter int unsigned REG_NUM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        ahb_bus_sel,
  output logic        ahb_bus_wr,
  output logic        ahb_bus_rd,
  output logic [3:0]  ahb_bus_addr,
  output logic [3:0]  ahb_bus_bsel,
  output logic [31:0] ahb_bus_wdata,
  input  logic [31:0] ahb_bus_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD2, ERR1, ERR2} state_t;

  state_t     state, state_next;
  logic [3:0] cap_addr, cap_bsel, req_bsel;
  logic [3:0] widx;
  logic       req_err, accept;
  logic       unused_bits;

  assign widx        = haddr[5:2];
  assign unused_bits = ^{haddr[31:6], htrans[0]};

  // Byte lanes and legality of the address-phase request
  always_comb begin
    req_bsel = 4'b0000;
    req_err  = 1'b0;
    case (hsize)
      3'd0: req_bsel = 4'b0001 << haddr[1:0];
      3'd1: begin
        req_bsel = haddr[1] ? 4'b1100 : 4'b0011;
        req_err  = haddr[0];
      end
      3'd2: begin
        req_bsel = 4'b1111;
        req_err  = |haddr[1:0];
      end
      default: req_err = 1'b1;
    endcase
    if ({28'd0, widx} >= REG_NUM) req_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cap_addr <= 4'd0;
      cap_bsel <= 4'd0;
      hrdata   <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_addr <= widx;
        cap_bsel <= req_bsel;
      end
      if (state == RD) hrdata <= ahb_bus_rdata;
    end
  end

  always_comb begin
    state_next    = IDLE;
    hreadyout     = 1'b1;
    hresp         = 1'b0;
    ahb_bus_sel   = 1'b0;
    ahb_bus_wr    = 1'b0;
    ahb_bus_rd    = 1'b0;
    ahb_bus_addr  = 4'd0;
    ahb_bus_bsel  = 4'd0;
    ahb_bus_wdata = 32'd0;
    case (state)
      WR: begin
        ahb_bus_sel   = 1'b1;
        ahb_bus_wr    = 1'b1;
        ahb_bus_addr  = cap_addr;
        ahb_bus_bsel  = cap_bsel;
        ahb_bus_wdata = hwdata;
      end
      RD: begin
        ahb_bus_sel  = 1'b1;
        ahb_bus_rd   = 1'b1;
        ahb_bus_addr = cap_addr;
        ahb_bus_bsel = cap_bsel;
        hreadyout    = 1'b0;
      end
      ERR1: begin
        hresp     = 1'b1;
        hreadyout = 1'b0;
      end
      ERR2: hresp = 1'b1;
      default: ;
    endcase

    // A new address phase is only taken while the current data phase is completing
    accept = hsel & hready_in & htrans[1] & hreadyout;
    case (state)
      RD:   state_next = RD2;
      ERR1: state_next = ERR2;
      default: begin
        if (accept) state_next = req_err ? ERR1 : (hwrite ? WR : RD);
        else        state_next = IDLE;
      end
    endcase
  end

endmodule
